// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
//   Bundles every non-clock signal of the fetch stage: decode-side control,
//   the synchronous instruction-memory port and the IF/ID outputs.
//
//   master : the fetch stage (drives PC/memory address and the IF/ID slot)
//   slave  : the environment (decode control + instruction memory)
//
//   Flow control: there is no valid/ready pair. Decode stalls the stage with
//   en_pc / en_ifid (0 = hold). flushed=1 marks the IF/ID slot as a bubble.
//   imem_en qualifies a read whose data appears on imem_rdata one cycle
//   later. The memory must hold imem_rdata while imem_en=0.
// ---------------------------------------------------------------------------
interface fetch_stage_if;
  logic        en_pc;
  logic        en_ifid;
  logic        flush_ifid;
  logic        jump_pred;
  logic [15:0] jump_pred_adr;
  logic        jump_pred_miss;
  logic [15:0] pcinc_evac;
  logic        jump_pred_adr_miss;
  logic [15:0] jump_adr_ex;
  logic        is_halt_id;
  logic [15:0] imem_adr;
  logic        imem_en;
  logic [15:0] imem_rdata;
  logic [15:0] inst_id;
  logic [15:0] pcinc_id;
  logic        flushed;
  logic        halted;

  modport master (
    input  en_pc, en_ifid, flush_ifid, jump_pred, jump_pred_adr,
           jump_pred_miss, pcinc_evac, jump_pred_adr_miss, jump_adr_ex,
           is_halt_id, imem_rdata,
    output imem_adr, imem_en, inst_id, pcinc_id, flushed, halted
  );

  modport slave (
    output en_pc, en_ifid, flush_ifid, jump_pred, jump_pred_adr,
           jump_pred_miss, pcinc_evac, jump_pred_adr_miss, jump_adr_ex,
           is_halt_id, imem_rdata,
    input  imem_adr, imem_en, inst_id, pcinc_id, flushed, halted
  );
endinterface

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch plus IF/ID pipeline register, upstream of decode.
//   Owns the PC, drives the synchronous instruction memory and presents
//   inst_id / pcinc_id / flushed to decode. Honors stall, flush and the
//   three prediction redirects, and stops fetching after a halt.
//
//   Ports:
//     clk   in  rising-edge clock
//     reset in  asynchronous, active-high
//     bus   fetch_stage_if.master (controls in, imem port, IF/ID outputs)
//
//   The instruction half of the IF/ID register is the memory's own output
//   register: imem_en is dropped whenever the slot must hold or become a
//   bubble, so only pcinc_id and flushed are stored here.
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INST = 16'h0000
) (
  input logic          clk,
  input logic          reset,
  fetch_stage_if.master bus
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [15:0] pc_q;
  logic [15:0] pc_plus1;
  logic [15:0] next_pc;
  logic [15:0] pcinc_id_q;
  logic        flushed_q;
  logic        any_miss;
  logic        is_run;

  assign pc_plus1 = pc_q + 16'd1;
  assign any_miss = bus.jump_pred_miss | bus.jump_pred_adr_miss;
  assign is_run   = (state_q == ST_RUN);

  // Next-PC select, strict priority: not-taken miss, wrong-target miss,
  // predicted taken, sequential.
  always_comb begin
    next_pc = pc_plus1;
    if (bus.jump_pred_miss)          next_pc = bus.pcinc_evac;
    else if (bus.jump_pred_adr_miss) next_pc = bus.jump_adr_ex;
    else if (bus.jump_pred)          next_pc = bus.jump_pred_adr;
  end

  // A miss means the halt (if any) sat on a wrong path, so it both blocks
  // entry to HALTED and pulls the FSM back out of it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (bus.is_halt_id && bus.en_ifid && !any_miss) state_d = ST_HALTED;
      ST_HALTED: if (any_miss) state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // Misses load the PC unconditionally; a plain jump_pred under en_pc=0 is
  // dropped and decode re-asserts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else if (any_miss || (bus.en_pc && is_run)) begin
      pc_q <= next_pc;
    end
  end

  // IF/ID slot: flush beats hold; HALTED turns the slot into a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcinc_id_q <= 16'h0000;
      flushed_q  <= 1'b1;
    end else if (bus.flush_ifid) begin
      flushed_q  <= 1'b1;
    end else if (bus.en_ifid && is_run) begin
      flushed_q  <= 1'b0;
      pcinc_id_q <= pc_plus1;
    end else if (!is_run) begin
      flushed_q  <= 1'b1;
    end
  end

  assign bus.imem_adr = pc_q;
  assign bus.imem_en  = bus.en_ifid & ~bus.flush_ifid & is_run;
  assign bus.inst_id  = flushed_q ? NOP_INST : bus.imem_rdata;
  assign bus.pcinc_id = pcinc_id_q;
  assign bus.flushed  = flushed_q;
  assign bus.halted   = (state_q == ST_HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//   Bench for fetch_stage. dut_a (RESET_PC=0, NOP=F00D) runs a table of
//   per-cycle vectors; dut_b (RESET_PC=FFFE) covers PC wrap. Both memories
//   return 16'h1000 + address.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [15:0] NOP_A = 16'hF00D;

  logic clk;
  logic reset;
  logic reset_b;

  fetch_stage_if bus_a ();
  fetch_stage_if bus_b ();

  fetch_stage #(.RESET_PC(16'h0000), .NOP_INST(NOP_A)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
  );

  fetch_stage #(.RESET_PC(16'hFFFE), .NOP_INST(16'h0000)) dut_b (
    .clk(clk), .reset(reset_b), .bus(bus_b)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memories ----------------
  always_ff @(posedge clk) begin
    if (bus_a.imem_en) bus_a.imem_rdata <= 16'h1000 + bus_a.imem_adr;
  end
  always_ff @(posedge clk) begin
    if (bus_b.imem_en) bus_b.imem_rdata <= 16'h1000 + bus_b.imem_adr;
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic        en_pc, en_ifid, flush, halt;
    logic        jp, miss, amiss;
    logic [15:0] jpa, evac, jex;
    logic [15:0] exp_adr;
    logic        exp_en;
    logic [15:0] exp_inst, exp_pcinc;
    logic        exp_fl, exp_h;
  } vec_t;

  // ctl = {en_pc, en_ifid, flush_ifid, is_halt_id}; rd = {jump_pred, miss, adr_miss}
  function automatic vec_t mk(input logic [3:0] ctl, input logic [2:0] rd,
                              input logic [15:0] jpa, input logic [15:0] evac,
                              input logic [15:0] jex, input logic [15:0] adr,
                              input logic en, input logic [15:0] inst,
                              input logic [15:0] pcinc, input logic fl,
                              input logic h);
    vec_t v;
    v.en_pc = ctl[3]; v.en_ifid = ctl[2]; v.flush = ctl[1]; v.halt = ctl[0];
    v.jp = rd[2]; v.miss = rd[1]; v.amiss = rd[0];
    v.jpa = jpa; v.evac = evac; v.jex = jex;
    v.exp_adr = adr; v.exp_en = en;
    v.exp_inst = inst; v.exp_pcinc = pcinc; v.exp_fl = fl; v.exp_h = h;
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  logic [33:0] exp_q[$];
  int n_cmp;
  int n_err;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic sb_pop(input string name, input logic [33:0] got);
    logic [33:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = exp_q.pop_front();
    chk({name, ".inst_id"},  {16'h0, got[33:18]}, {16'h0, e[33:18]});
    chk({name, ".pcinc_id"}, {16'h0, got[17:2]},  {16'h0, e[17:2]});
    chk({name, ".flushed"},  {31'h0, got[1]},     {31'h0, e[1]});
    chk({name, ".halted"},   {31'h0, got[0]},     {31'h0, e[0]});
  endtask

  function automatic logic [33:0] outs_a();
    return {bus_a.inst_id, bus_a.pcinc_id, bus_a.flushed, bus_a.halted};
  endfunction

  function automatic logic [33:0] outs_b();
    return {bus_b.inst_id, bus_b.pcinc_id, bus_b.flushed, bus_b.halted};
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_a(input vec_t v);
    bus_a.en_pc              = v.en_pc;
    bus_a.en_ifid            = v.en_ifid;
    bus_a.flush_ifid         = v.flush;
    bus_a.is_halt_id         = v.halt;
    bus_a.jump_pred          = v.jp;
    bus_a.jump_pred_miss     = v.miss;
    bus_a.jump_pred_adr_miss = v.amiss;
    bus_a.jump_pred_adr      = v.jpa;
    bus_a.pcinc_evac         = v.evac;
    bus_a.jump_adr_ex        = v.jex;
  endtask

  // Entered at posedge+1; returns at the next posedge+1.
  task automatic step_a(input vec_t v, input string name);
    drive_a(v);
    #1;
    chk({name, ".imem_adr"}, {16'h0, bus_a.imem_adr}, {16'h0, v.exp_adr});
    chk({name, ".imem_en"},  {31'h0, bus_a.imem_en},  {31'h0, v.exp_en});
    exp_q.push_back({v.exp_inst, v.exp_pcinc, v.exp_fl, v.exp_h});
    @(posedge clk);
    #1;
    sb_pop(name, outs_a());
  endtask

  vec_t tbl[$];
  vec_t idle;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset   = 1'b1;
    reset_b = 1'b1;
    idle = mk(4'b1100, 3'b000, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1, 16'h0, 16'h0, 1'b0, 1'b0);
    drive_a(idle);
    bus_b.en_pc = 1'b1; bus_b.en_ifid = 1'b1; bus_b.flush_ifid = 1'b0;
    bus_b.is_halt_id = 1'b0; bus_b.jump_pred = 1'b0; bus_b.jump_pred_miss = 1'b0;
    bus_b.jump_pred_adr_miss = 1'b0; bus_b.jump_pred_adr = 16'h0;
    bus_b.pcinc_evac = 16'h0; bus_b.jump_adr_ex = 16'h0;

    //              ctl      rd      jpa      evac     jex      adr      en    inst     pcinc    fl    h
    tbl.push_back(mk(4'b1100, 3'b000, 16'h0,   16'h0,   16'h0,   16'h0000, 1'b1, 16'h1000, 16'h0001, 1'b0, 1'b0));
    tbl.push_back(mk(4'b1100, 3'b000, 16'h0,   16'h0,   16'h0,   16'h0001, 1'b1, 16'h1001, 16'h0002, 1'b0, 1'b0));
    tbl.push_back(mk(4'b1100, 3'b000, 16'h0,   16'h0,   16'h0,   16'h0002, 1'b1, 16'h1002, 16'h0003, 1'b0, 1'b0));
    tbl.push_back(mk(4'b0000, 3'b000, 16'h0,   16'h0,   16'h0,   16'h0003, 1'b0, 16'h1002, 16'h0003, 1'b0, 1'b0));
    tbl.push_back(mk(4'b0000, 3'b000, 16'h0,   16'h0,   16'h0,   16'h0003, 1'b0, 16'h1002, 16'h0003, 1'b0, 1'b0));
    tbl.push_back(mk(4'b0000, 3'b000, 16'h0,   16'h0,   16'h0,   16'h0003, 1'b0, 16'h1002, 16'h0003, 1'b0, 1'b0));
    tbl.push_back(mk(4'b1100, 3'b000, 16'h0,   16'h0,   16'h0,   16'h0003, 1'b1, 16'h1003, 16'h0004, 1'b0, 1'b0));
    tbl.push_back(mk(4'b1110, 3'b100, 16'h0040, 16'h0,  16'h0,   16'h0004, 1'b0, NOP_A,    16'h0004, 1'b1, 1'b0));
    tbl.push_back(mk(4'b1100, 3'b000, 16'h0,   16'h0,   16'h0,   16'h0040, 1'b1, 16'h1040, 16'h0041, 1'b0, 1'b0));
    tbl.push_back(mk(4'b1100, 3'b000, 16'h0,   16'h0,   16'h0,   16'h0041, 1'b1, 16'h1041, 16'h0042, 1'b0, 1'b0));
    tbl.push_back(mk(4'b0100, 3'b110, 16'h0050, 16'h0008, 16'h0, 16'h0042, 1'b1, 16'h1042, 16'h0043, 1'b0, 1'b0));
    tbl.push_back(mk(4'b1100, 3'b000, 16'h0,   16'h0,   16'h0,   16'h0008, 1'b1, 16'h1008, 16'h0009, 1'b0, 1'b0));
    tbl.push_back(mk(4'b1100, 3'b011, 16'h0,   16'h0010, 16'h0030, 16'h0009, 1'b1, 16'h1009, 16'h000A, 1'b0, 1'b0));
    tbl.push_back(mk(4'b1100, 3'b000, 16'h0,   16'h0,   16'h0,   16'h0010, 1'b1, 16'h1010, 16'h0011, 1'b0, 1'b0));
    tbl.push_back(mk(4'b0100, 3'b100, 16'h0060, 16'h0,  16'h0,   16'h0011, 1'b1, 16'h1011, 16'h0012, 1'b0, 1'b0));
    tbl.push_back(mk(4'b1100, 3'b000, 16'h0,   16'h0,   16'h0,   16'h0011, 1'b1, 16'h1011, 16'h0012, 1'b0, 1'b0));
    tbl.push_back(mk(4'b1100, 3'b101, 16'h0070, 16'h0,  16'h0030, 16'h0012, 1'b1, 16'h1012, 16'h0013, 1'b0, 1'b0));
    tbl.push_back(mk(4'b1100, 3'b000, 16'h0,   16'h0,   16'h0,   16'h0030, 1'b1, 16'h1030, 16'h0031, 1'b0, 1'b0));
    tbl.push_back(mk(4'b1010, 3'b000, 16'h0,   16'h0,   16'h0,   16'h0031, 1'b0, NOP_A,    16'h0031, 1'b1, 1'b0));
    tbl.push_back(mk(4'b1100, 3'b000, 16'h0,   16'h0,   16'h0,   16'h0032, 1'b1, 16'h1032, 16'h0033, 1'b0, 1'b0));
    tbl.push_back(mk(4'b1101, 3'b000, 16'h0,   16'h0,   16'h0,   16'h0033, 1'b1, 16'h1033, 16'h0034, 1'b0, 1'b1));
    tbl.push_back(mk(4'b1100, 3'b000, 16'h0,   16'h0,   16'h0,   16'h0034, 1'b0, NOP_A,    16'h0034, 1'b1, 1'b1));
    tbl.push_back(mk(4'b1100, 3'b100, 16'h0077, 16'h0,  16'h0,   16'h0034, 1'b0, NOP_A,    16'h0034, 1'b1, 1'b1));
    tbl.push_back(mk(4'b1100, 3'b001, 16'h0,   16'h0,   16'h0020, 16'h0034, 1'b0, NOP_A,   16'h0034, 1'b1, 1'b0));
    tbl.push_back(mk(4'b1100, 3'b000, 16'h0,   16'h0,   16'h0,   16'h0020, 1'b1, 16'h1020, 16'h0021, 1'b0, 1'b0));
    tbl.push_back(mk(4'b1101, 3'b010, 16'h0,   16'h0005, 16'h0,  16'h0021, 1'b1, 16'h1021, 16'h0022, 1'b0, 1'b0));
    tbl.push_back(mk(4'b1100, 3'b000, 16'h0,   16'h0,   16'h0,   16'h0005, 1'b1, 16'h1005, 16'h0006, 1'b0, 1'b0));
    tbl.push_back(mk(4'b1001, 3'b000, 16'h0,   16'h0,   16'h0,   16'h0006, 1'b0, 16'h1005, 16'h0006, 1'b0, 1'b0));
    tbl.push_back(mk(4'b1100, 3'b000, 16'h0,   16'h0,   16'h0,   16'h0007, 1'b1, 16'h1007, 16'h0008, 1'b0, 1'b0));

    // Reset values while reset is held.
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back({NOP_A, 16'h0000, 1'b1, 1'b0});
    sb_pop("reset_a", outs_a());
    chk("reset_a.imem_adr", {16'h0, bus_a.imem_adr}, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      step_a(tbl[i], $sformatf("vec%0d", i));
    end

    // Halt again, then async reset mid-cycle while HALTED.
    step_a(mk(4'b1101, 3'b000, 16'h0, 16'h0, 16'h0, 16'h0008, 1'b1, 16'h1008, 16'h0009, 1'b0, 1'b1), "rehalt");
    step_a(mk(4'b1100, 3'b000, 16'h0, 16'h0, 16'h0, 16'h0009, 1'b0, NOP_A, 16'h0009, 1'b1, 1'b1), "halted");
    #2;
    reset = 1'b1;
    #1;
    exp_q.push_back({NOP_A, 16'h0000, 1'b1, 1'b0});
    sb_pop("async_reset_a", outs_a());
    chk("async_reset_a.imem_adr", {16'h0, bus_a.imem_adr}, 32'h0);
    chk("async_reset_a.imem_en", {31'h0, bus_a.imem_en}, 32'h1);

    // dut_b: PC wrap from FFFE.
    @(posedge clk);
    #1;
    reset_b = 1'b0;
    #1;
    exp_q.push_back({16'h0000, 16'h0000, 1'b1, 1'b0});
    sb_pop("reset_b", outs_b());
    chk("reset_b.imem_adr", {16'h0, bus_b.imem_adr}, 32'h0000FFFE);
    exp_q.push_back({16'h0FFE, 16'hFFFF, 1'b0, 1'b0});
    exp_q.push_back({16'h0FFF, 16'h0000, 1'b0, 1'b0});
    exp_q.push_back({16'h1000, 16'h0001, 1'b0, 1'b0});
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      sb_pop($sformatf("wrap%0d", i), outs_b());
    end
    #2;
    reset_b = 1'b1;
    #1;
    exp_q.push_back({16'h0000, 16'h0000, 1'b1, 1'b0});
    sb_pop("async_reset_b", outs_b());
    chk("async_reset_b.imem_adr", {16'h0, bus_b.imem_adr}, 32'h0000FFFE);

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL leftover: %0d expected entries not consumed", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
